// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the Simple RISC CPU: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT sequencing.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and raise the sticky illegal flag.
module multicycle_control_unit #(
   parameter int unsigned OPCODE_W = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                instr_ready,
   output logic [2:0]          alu_ctrl,
   output logic                reg_write,
   output logic                mem_req,
   output logic                mem_we,
   input  logic                mem_ack,
   output logic                pc_inc,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    retired
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WRITEBACK,
      S_HALT
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [OPCODE_W-1:0] r_opcode;
   logic [CNT_W-1:0]    r_retired;

   logic       w_hi_zero;
   logic [3:0] w_op;
   logic       w_is_alu;
   logic       w_is_load;
   logic       w_is_store;
   logic       w_is_nop;
   logic       w_is_halt;
   logic       w_is_undef;
   logic [2:0] w_alu_dec;
`ifdef CU_ILLEGAL_TRAP_EN
   logic       w_trap;
`endif

   // Any set bit above bit 3 makes the opcode undefined; shifting avoids a null slice when OPCODE_W == 4.
   assign w_op      = r_opcode[3:0];
   assign w_hi_zero = ((r_opcode >> 4) == '0);

   always_comb begin
      w_is_alu   = 1'b0;
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_is_nop   = 1'b0;
      w_is_halt  = 1'b0;
      w_is_undef = 1'b0;
      w_alu_dec  = 3'b000;
      if (w_hi_zero) begin
         case (w_op)
            4'b0000: w_is_nop = 1'b1;
            4'b0001: w_is_alu = 1'b1;
            4'b0010: begin w_is_alu = 1'b1; w_alu_dec = 3'b001; end
            4'b0011: begin w_is_alu = 1'b1; w_alu_dec = 3'b100; end
            4'b0100: begin w_is_alu = 1'b1; w_alu_dec = 3'b101; end
            4'b0101: w_is_load  = 1'b1;
            4'b0110: w_is_store = 1'b1;
            4'b1111: w_is_halt  = 1'b1;
            default: w_is_undef = 1'b1;
         endcase
      end else begin
         w_is_undef = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      instr_ready = 1'b0;
      alu_ctrl    = 3'b000;
      reg_write   = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      pc_inc      = 1'b0;
      halted      = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
      w_trap      = 1'b0;
`endif
      case (r_state)
         S_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (w_is_alu || w_is_load || w_is_store) begin
               w_state_nxt = S_EXECUTE;
            end else if (w_is_halt) begin
               w_state_nxt = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
            end else if (w_is_undef) begin
               w_state_nxt = S_HALT;
               w_trap      = 1'b1;
`endif
            end else begin
               pc_inc      = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         S_EXECUTE: begin
            alu_ctrl    = w_alu_dec;
            w_state_nxt = (w_is_load || w_is_store) ? S_MEM : S_WRITEBACK;
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = w_is_store;
            if (mem_ack) begin
               if (w_is_store) begin
                  pc_inc      = 1'b1;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_state_nxt = S_WRITEBACK;
               end
            end
         end
         S_WRITEBACK: begin
            alu_ctrl    = w_alu_dec;
            reg_write   = 1'b1;
            pc_inc      = 1'b1;
            w_state_nxt = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_opcode  <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_FETCH && instr_valid) r_opcode <= opcode;
         if (pc_inc) r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign retired = r_retired;

`ifdef CU_ILLEGAL_TRAP_EN
   logic r_illegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_illegal <= 1'b0;
      end else if (w_trap) begin
         r_illegal <= 1'b1;
      end
   end

   assign illegal = r_illegal;
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, random instruction stream vs. trace model,
// and hand sequences for HALT, undefined opcodes, counter wrap and reset during MEM.
module tb_multicycle_control_unit;

   localparam int unsigned OW = 6;
   localparam int unsigned CW = 4;
`ifdef CU_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_valid = 1'b0;
   logic [OW-1:0] opcode = '0;
   logic          mem_ack = 1'b0;
   logic          instr_ready;
   logic [2:0]    alu_ctrl;
   logic          reg_write;
   logic          mem_req;
   logic          mem_we;
   logic          pc_inc;
   logic          halted;
   logic          illegal;
   logic [CW-1:0] retired;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned exp_ret = 0;
   bit          exp_ill = 1'b0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.OPCODE_W(OW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
      .instr_ready(instr_ready), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
      .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .pc_inc(pc_inc),
      .halted(halted), .illegal(illegal), .retired(retired)
   );

   typedef struct packed {
      logic       rdy;
      logic [2:0] alu;
      logic       rw;
      logic       mreq;
      logic       mwe;
      logic       pinc;
      logic       hlt;
      logic       ill;
   } obs_t;

   typedef struct {
      logic [OW-1:0] op;
      int unsigned   n;
      logic [2:0]    alu;
      int unsigned   len;
      bit            rw;
      bit            we;
      int unsigned   pinc;
      int unsigned   mcyc;
   } vec_t;

   obs_t tr_q[$];
   vec_t vt[$];

   function automatic obs_t mk(input bit rdy, input logic [2:0] alu, input bit rw, input bit mq,
                               input bit we, input bit pi, input bit hl, input bit il);
      obs_t o;
      o.rdy = rdy; o.alu = alu; o.rw = rw; o.mreq = mq;
      o.mwe = we;  o.pinc = pi; o.hlt = hl; o.ill = il;
      return o;
   endfunction

   function automatic obs_t observe();
      return mk(instr_ready, alu_ctrl, reg_write, mem_req, mem_we, pc_inc, halted, illegal);
   endfunction

   function automatic bit is_undef(input logic [OW-1:0] op);
      return (op > 6'd15) || (op >= 6'd7 && op <= 6'd14);
   endfunction

   function automatic logic [2:0] alu_of(input logic [OW-1:0] op);
      case (op)
         6'd2:    return 3'b001;
         6'd3:    return 3'b100;
         6'd4:    return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected per-cycle outputs from the handshake cycle up to (not including) the return to FETCH.
   task automatic build_trace(input logic [OW-1:0] op, input int unsigned n);
      bit st;
      tr_q.delete();
      tr_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, exp_ill));
      if (op >= 6'd1 && op <= 6'd4) begin
         tr_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, exp_ill));
         tr_q.push_back(mk(0, alu_of(op), 0, 0, 0, 0, 0, exp_ill));
         tr_q.push_back(mk(0, alu_of(op), 1, 0, 0, 1, 0, exp_ill));
      end else if (op == 6'd5 || op == 6'd6) begin
         st = (op == 6'd6);
         tr_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, exp_ill));
         tr_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, exp_ill));
         for (int unsigned k = 0; k <= n; k++)
            tr_q.push_back(mk(0, 0, 0, 1, st, st && (k == n), 0, exp_ill));
         if (!st) tr_q.push_back(mk(0, 0, 1, 0, 0, 1, 0, exp_ill));
      end else if (op == 6'd15 || (TRAP && is_undef(op))) begin
         tr_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, exp_ill));
         if (is_undef(op)) exp_ill = 1'b1;
         for (int unsigned k = 0; k < 20; k++)
            tr_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, exp_ill));
      end else begin
         tr_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, exp_ill));
      end
   endtask

   task automatic run_instr(input logic [OW-1:0] op, input int unsigned n);
      bit is_mem;
      is_mem = (op == 6'd5 || op == 6'd6);
      build_trace(op, n);
      for (int unsigned i = 0; i < tr_q.size(); i++) begin
         instr_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         opcode      = (i == 0) ? op : OW'($urandom);
         if (is_mem && i >= 3) mem_ack = (i == 3 + n);
         else                  mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check($sformatf("op%0h c%0d outputs", op, i), 32'(observe()), 32'(tr_q[i]));
         check($sformatf("op%0h c%0d retired", op, i), 32'(retired), exp_ret % 16);
         if (tr_q[i].pinc) exp_ret++;
         @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      mem_ack     = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned len = 0, mcyc = 0, pcnt = 0;
      logic [2:0]  alu_ex = 3'b000;
      bit          rw = 1'b0, we = 1'b0;
      instr_valid = 1'b1;
      opcode      = v.op;
      for (int unsigned i = 0; i < 50 && len == 0; i++) begin
         if (i > 0) begin instr_valid = 1'b0; opcode = '0; end
         mem_ack = mem_req && (mcyc == v.n);
         @(negedge clk);
         if (i > 0 && instr_ready) begin
            len = i;
         end else begin
            if (i == 2) alu_ex = alu_ctrl;
            if (reg_write) rw = 1'b1;
            if (mem_req && mem_we) we = 1'b1;
            if (mem_req) mcyc++;
            if (pc_inc) pcnt++;
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      exp_ret += v.pinc;
      check($sformatf("vec op%0h len", v.op), len, v.len);
      check($sformatf("vec op%0h alu", v.op), 32'(alu_ex), 32'(v.alu));
      check($sformatf("vec op%0h reg_write", v.op), 32'(rw), 32'(v.rw));
      check($sformatf("vec op%0h mem_we", v.op), 32'(we), 32'(v.we));
      check($sformatf("vec op%0h mem_req cycles", v.op), mcyc, v.mcyc);
      check($sformatf("vec op%0h pc_inc count", v.op), pcnt, v.pinc);
      check($sformatf("vec op%0h retired", v.op), 32'(retired), exp_ret % 16);
   endtask

   task automatic do_reset();
      rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; opcode = '0;
      @(negedge clk);
      check("reset outputs", 32'(observe()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0)));
      check("reset retired", 32'(retired), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ret = 0;
      exp_ill = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected to finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [OW-1:0] rop;
      int unsigned   pick;

      //              op     n  alu     len rw we pinc mcyc
      vt.push_back('{6'd1, 0, 3'b000, 4, 1, 0, 1, 0});
      vt.push_back('{6'd2, 0, 3'b001, 4, 1, 0, 1, 0});
      vt.push_back('{6'd3, 0, 3'b100, 4, 1, 0, 1, 0});
      vt.push_back('{6'd4, 0, 3'b101, 4, 1, 0, 1, 0});
      vt.push_back('{6'd5, 3, 3'b000, 8, 1, 0, 1, 4});
      vt.push_back('{6'd5, 0, 3'b000, 5, 1, 0, 1, 1});
      vt.push_back('{6'd6, 0, 3'b000, 4, 0, 1, 1, 1});
      vt.push_back('{6'd6, 2, 3'b000, 6, 0, 1, 1, 3});
      vt.push_back('{6'd0, 0, 3'b000, 2, 0, 0, 1, 0});

      do_reset();
      foreach (vt[i]) run_vec(vt[i]);

      // Random instruction stream; retired wraps several times at CNT_W = 4.
      do_reset();
      for (int unsigned k = 0; k < 80; k++) begin
         pick = $urandom_range(0, 8);
         case (pick)
            0:       rop = 6'd0;
            7:       rop = 6'd5;
            8:       rop = (TRAP) ? 6'd6 : OW'($urandom_range(7, 14));
            default: rop = OW'(pick);
         endcase
         run_instr(rop, $urandom_range(0, 4));
      end

      // NOP then HALT: halt is absorbing and not counted.
      do_reset();
      run_instr(6'd0, 0);
      run_instr(6'd15, 0);
      check("halt retired", 32'(retired), 1);

      // Undefined opcodes: 1010 and one with a bit above bit 3 set.
      do_reset();
      run_instr(6'd2, 0);
      run_instr(6'b001010, 0);
      check("undef 1010 illegal", 32'(illegal), 32'(TRAP));
      check("undef 1010 retired", 32'(retired), TRAP ? 1 : 2);
      do_reset();
      run_instr(6'b010100, 0);
      check("undef hi-bit illegal", 32'(illegal), 32'(TRAP));

      // Counter wrap after 16 NOPs.
      do_reset();
      for (int unsigned k = 0; k < 15; k++) run_instr(6'd0, 0);
      check("retired before wrap", 32'(retired), 15);
      run_instr(6'd0, 0);
      check("retired wrap", 32'(retired), 0);

      // Asynchronous reset in the middle of a LOAD's MEM phase.
      run_instr(6'd1, 0);
      instr_valid = 1'b1; opcode = 6'd5;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mem_req before rst", 32'(mem_req), 1);
      #2 rst = 1'b1;
      #1;
      check("rst mid-MEM outputs", 32'(observe()), 32'(mk(1, 0, 0, 0, 0, 0, 0, 0)));
      check("rst mid-MEM retired", 32'(retired), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_ret = 0;
      exp_ill = 1'b0;
      run_instr(6'd6, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle opcode decoder of the Simple RISC CPU. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives ALU control, register-file write enable, a data-memory request handshake and PC increment. It adds load/store, NOP and HALT handling plus a retired-instruction counter. It sits between the instruction register / fetch path and the datapath (ALU, register file, data memory).

## Interface
Parameters:
- OPCODE_W, 4, opcode width; minimum 4. Decoding uses bits [3:0]; any nonzero bit above bit 3 makes the opcode undefined.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  opcode on `opcode` is valid.
- opcode  input  OPCODE_W  instruction opcode; captured on fetch handshake.
- instr_ready  output  1  controller ready to accept an instruction.
- alu_ctrl  output  3  ALU operation select.
- reg_write  output  1  register-file write enable.
- mem_req  output  1  data-memory request; held until acknowledged.
- mem_we  output  1  1 = store, 0 = load; meaningful only while mem_req = 1.
- mem_ack  input  1  data memory completes the request this cycle.
- pc_inc  output  1  one-cycle pulse; advance PC.
- halted  output  1  controller is in HALT.
- illegal  output  1  sticky flag: undefined opcode trapped. Constant 0 without the macro.
- retired  output  CNT_W  count of completed instructions.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Encoding is free.
- Opcodes and their ALU control values:
  - 0001 ADD → 000
  - 0010 SUB → 001
  - 0011 AND → 100
  - 0100 OR → 101
  - 0101 LOAD → 000 (address add)
  - 0110 STORE → 000
  - 0000 NOP
  - 1111 HALT
  - All other opcodes are undefined.
- FETCH: instr_ready = 1. On instr_valid & instr_ready, latch opcode into an internal register and go to DECODE. Otherwise stay.
- DECODE (1 cycle):
  - ALU ops, LOAD and STORE → EXECUTE.
  - NOP → FETCH, with pc_inc = 1 in this cycle.
  - HALT → HALT.
  - Undefined opcode → handled as NOP (see Configuration).
- EXECUTE (1 cycle): alu_ctrl = decoded value.
  - ALU ops → WRITEBACK.
  - LOAD / STORE → MEM.
- MEM: mem_req = 1 and alu_ctrl = 000. mem_we = 1 for STORE, 0 for LOAD.
  - mem_req stays asserted every cycle until mem_ack = 1.
  - On ack: LOAD → WRITEBACK. STORE → FETCH, with pc_inc = 1 in the ack cycle.
- WRITEBACK (1 cycle): reg_write = 1, alu_ctrl held at the decoded value, pc_inc = 1 → FETCH.
- HALT: absorbing state. halted = 1, instr_ready = 0. All strobes are 0. Only rst exits.
- Default outputs: alu_ctrl = 000 and all strobes 0 outside the states listed above.
- retired: increments by 1 in every cycle where pc_inc = 1; wraps from 2^CNT_W−1 to 0. HALT is not counted.
- mem_ack outside MEM is ignored.

## Timing
- Reset (asynchronous, immediate):
  - State → FETCH; latched opcode → 0; retired → 0; illegal → 0.
  - Outputs: instr_ready = 1; all other outputs 0.
- Reset mid-operation aborts the instruction. No pc_inc or reg_write is emitted while rst is asserted.
- Let cycle 0 be the fetch-handshake cycle. FETCH is re-entered, with instr_ready = 1, in cycle:
  - ALU op: 4. Writeback in cycle 3.
  - NOP: 2.
  - LOAD: 5 + N, for mem_ack arriving N cycles after mem_req rises.
  - STORE: 4 + N.
- Back-to-back instructions are accepted only in FETCH. instr_valid is ignored in every other state.
- pc_inc is asserted for exactly one cycle per retired instruction.
- Outputs are combinational from state and latched opcode, except pc_inc in MEM, which also depends on mem_ack.

## Configuration
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to HALT, sets illegal = 1 (sticky until rst), does not pulse pc_inc, and does not increment retired.
- Undefined: an undefined opcode behaves exactly as NOP (pc_inc pulse, counted). The illegal output is tied to 0.

## Test plan
- Reset then SUB (0010) with instr_valid held high: alu_ctrl = 001 in cycles 2–3; reg_write = 1 and pc_inc = 1 only in cycle 3; instr_ready = 1 again in cycle 4; retired = 1.
- LOAD with mem_ack delayed 3 cycles: mem_req = 1 and mem_we = 0 for 4 consecutive cycles; reg_write pulse on the following cycle; total 8 cycles to return to FETCH.
- STORE with mem_ack in the first MEM cycle: mem_we = 1; pc_inc pulses in the ack cycle; no reg_write; FETCH in cycle 4.
- NOP then HALT (1111): retired = 1; halted = 1 from cycle 4; instr_ready stays 0 for 20 cycles despite instr_valid = 1.
- Opcode 1010: with CU_ILLEGAL_TRAP_EN, illegal = 1, halted = 1 and retired unchanged. Without the macro, NOP behaviour and retired increments.
- CNT_W = 4, 16 NOPs → retired wraps to 0. Assert rst during MEM → mem_req drops immediately and all outputs take their reset values.
